// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing logic: control codes, FSM encoding, width default.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SRA  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter2.sv
// Two-input arbiter: round-robin on contention, or fixed priority to input 0.
module rr_arbiter2 #(
  parameter int PRIO_MODE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_grant;

  // Contention goes to the port that did not win last time (or always port 0).
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = ((PRIO_MODE == 1) || last_grant) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept && (grant != 2'b00)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Arbitrates two requesters onto one external combinational ALU, one operation in flight.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int PRIO_MODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [2:0]      req0_ctrl,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [2:0]      req1_ctrl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_zero
);

  arb_state_t      state;
  logic [1:0]      grant;
  logic            idle;
  logic [XLEN-1:0] op_a_p0;
  logic [XLEN-1:0] op_b_p0;
  logic [2:0]      op_ctrl_p0;
  logic            op_id_p0;

  assign idle = (state == IDLE);

  rr_arbiter2 #(
    .PRIO_MODE(PRIO_MODE)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid ({req1_valid, req0_valid}),
    .accept(idle),
    .grant (grant)
  );

  assign req0_ready = idle & grant[0];
  assign req1_ready = idle & grant[1];

  assign alu_a    = op_a_p0;
  assign alu_b    = op_b_p0;
  assign alu_ctrl = op_ctrl_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_a_p0    <= '0;
      op_b_p0    <= '0;
      op_ctrl_p0 <= ALU_ADD;
      op_id_p0   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_id     <= 1'b0;
    end else begin
      case (state)
        // Request stage: latch the granted operands into the op registers.
        IDLE: begin
          if (grant[0]) begin
            op_a_p0    <= req0_a;
            op_b_p0    <= req0_b;
            op_ctrl_p0 <= req0_ctrl;
            op_id_p0   <= 1'b0;
            state      <= EXEC;
          end else if (grant[1]) begin
            op_a_p0    <= req1_a;
            op_b_p0    <= req1_b;
            op_ctrl_p0 <= req1_ctrl;
            op_id_p0   <= 1'b1;
            state      <= EXEC;
          end
        end
        // Execute stage: ALU has seen stable operands for a full cycle.
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_id     <= op_id_p0;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        // Response stage: hold until the consumer takes it.
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: timeline reference model plus directed and random scenarios.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [2:0]  req0_ctrl = 0, req1_ctrl = 0;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic        alu_zero;
  logic        rsp_valid, rsp_id, rsp_zero;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;

  logic        p0_valid = 0, p1_valid = 0, p0_ready, p1_ready;
  logic [31:0] p0_a = 0, p0_b = 0, p1_a = 0, p1_b = 0;
  logic [31:0] p_alu_a, p_alu_b, p_alu_result, p_rsp_result;
  logic [2:0]  p_alu_ctrl;
  logic        p_alu_zero, p_rsp_valid, p_rsp_id, p_rsp_zero;
  logic        p_rsp_ready = 1'b1;

  int errors = 0;
  int checks = 0;

  typedef struct {logic id; logic [31:0] res; logic z;} rsp_t;
  int   gq[$];
  rsp_t rq[$];

  logic        m_busy = 0;
  int          m_age = 0;
  logic        m_last = 1;
  logic        m_id = 0;
  logic [31:0] m_a = 0, m_b = 0, m_res = 0;
  logic [2:0]  m_ctrl = 0;
  logic        m_zero = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] c);
    case (c)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b100:  return a << b[4:0];
      3'b101:  return {31'b0, $signed(a) < $signed(b)};
      3'b110:  return {31'b0, a < b};
      3'b111:  return $signed(a) >>> b[4:0];
      3'b010:  return a & b;
      default: return a | b;
    endcase
  endfunction

  assign alu_result   = alu_f(alu_a, alu_b, alu_ctrl);
  assign alu_zero     = (alu_result == 32'd0);
  assign p_alu_result = alu_f(p_alu_a, p_alu_b, p_alu_ctrl);
  assign p_alu_zero   = (p_alu_result == 32'd0);

  alu_share_arbiter #(.XLEN(32), .PRIO_MODE(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  alu_share_arbiter #(.XLEN(32), .PRIO_MODE(1)) dut_p (
    .clk(clk), .rst(rst),
    .req0_valid(p0_valid), .req0_ready(p0_ready), .req0_a(p0_a), .req0_b(p0_b),
    .req0_ctrl(ALU_ADD),
    .req1_valid(p1_valid), .req1_ready(p1_ready), .req1_a(p1_a), .req1_b(p1_b),
    .req1_ctrl(ALU_SUB),
    .alu_a(p_alu_a), .alu_b(p_alu_b), .alu_ctrl(p_alu_ctrl), .alu_result(p_alu_result),
    .alu_zero(p_alu_zero),
    .rsp_valid(p_rsp_valid), .rsp_ready(p_rsp_ready), .rsp_id(p_rsp_id),
    .rsp_result(p_rsp_result), .rsp_zero(p_rsp_zero)
  );

  // One clock of the reference timeline: accept at T, response visible from T+2 until taken.
  task automatic step();
    int   w;
    logic e0, e1, erv;
    @(negedge clk);
    w = -1;
    if (!m_busy) begin
      if (req0_valid && req1_valid) w = m_last ? 0 : 1;
      else if (req0_valid)          w = 0;
      else if (req1_valid)          w = 1;
    end
    e0  = (w == 0);
    e1  = (w == 1);
    erv = m_busy && (m_age >= 2);
    checks++;
    if (req0_ready !== e0) begin
      errors++; $display("FAIL req0_ready t=%0t got %b want %b", $time, req0_ready, e0);
    end
    checks++;
    if (req1_ready !== e1) begin
      errors++; $display("FAIL req1_ready t=%0t got %b want %b", $time, req1_ready, e1);
    end
    checks++;
    if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
      errors++; $display("FAIL both_ready t=%0t got 11 want at most one", $time);
    end
    checks++;
    if (rsp_valid !== erv) begin
      errors++; $display("FAIL rsp_valid t=%0t got %b want %b", $time, rsp_valid, erv);
    end
    if (erv) begin
      checks++;
      if (rsp_id !== m_id) begin
        errors++; $display("FAIL rsp_id t=%0t got %b want %b", $time, rsp_id, m_id);
      end
      checks++;
      if (rsp_result !== m_res) begin
        errors++; $display("FAIL rsp_result t=%0t got %h want %h", $time, rsp_result, m_res);
      end
      checks++;
      if (rsp_zero !== m_zero) begin
        errors++; $display("FAIL rsp_zero t=%0t got %b want %b", $time, rsp_zero, m_zero);
      end
    end
    if (m_busy && m_age == 1) begin
      checks++;
      if (alu_a !== m_a || alu_b !== m_b || alu_ctrl !== m_ctrl) begin
        errors++;
        $display("FAIL alu_operands t=%0t got %h/%h/%b want %h/%h/%b", $time,
                 alu_a, alu_b, alu_ctrl, m_a, m_b, m_ctrl);
      end
    end
    if (rst) begin
      m_busy = 0;
      m_last = 1;
    end else if (m_busy) begin
      if (erv && rsp_ready) begin
        rq.push_back('{m_id, m_res, m_zero});
        m_busy = 0;
      end else begin
        m_age++;
      end
    end else if (w >= 0) begin
      m_busy = 1;
      m_age  = 1;
      m_last = (w == 1);
      m_id   = (w == 1);
      m_a    = (w == 1) ? req1_a : req0_a;
      m_b    = (w == 1) ? req1_b : req0_b;
      m_ctrl = (w == 1) ? req1_ctrl : req0_ctrl;
      m_res  = alu_f(m_a, m_b, m_ctrl);
      m_zero = (m_res == 32'd0);
      gq.push_back(w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 0; req1_valid = 0; p0_valid = 0; p1_valid = 0;
    rsp_ready = 1; rst = 1;
    step();
    rst = 0;
    gq.delete();
    rq.delete();
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    m_busy = 0; m_last = 1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++;
    if (rsp_result !== 32'd0 || rsp_zero !== 1'b0 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_fields got %h/%b/%b want 0/0/0", rsp_result, rsp_zero, rsp_id);
    end
    checks++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== ALU_ADD) begin
      errors++; $display("FAIL reset_alu got %h/%h/%b want 0/0/000", alu_a, alu_b, alu_ctrl);
    end
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b%b want 00", req1_ready, req0_ready);
    end
  endtask

  task automatic test_single_op();
    req0_valid = 1; req0_a = 5; req0_b = 7; req0_ctrl = ALU_ADD; rsp_ready = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", req0_ready); end
    step();
    req0_valid = 0;
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd12 || rsp_zero !== 1'b0 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp got v=%b r=%0d z=%b id=%b want v=1 r=12 z=0 id=0",
               rsp_valid, rsp_result, rsp_zero, rsp_id);
    end
    step();
    step();
  endtask

  task automatic test_contention_rr();
    do_reset();
    req0_valid = 1; req0_a = 9; req0_b = 9; req0_ctrl = ALU_SUB;
    req1_valid = 1; req1_a = 1; req1_b = 1; req1_ctrl = ALU_ADD;
    repeat (9) step();
    req0_valid = 0; req1_valid = 0;
    checks++;
    if (gq.size() < 3 || gq[0] != 0 || gq[1] != 1 || gq[2] != 0) begin
      errors++; $display("FAIL rr_grant_order got n=%0d want 0,1,0", gq.size());
    end
    checks++;
    if (rq.size() < 2 || rq[0].id !== 1'b0 || rq[0].res !== 32'd0 || rq[0].z !== 1'b1 ||
        rq[1].id !== 1'b1 || rq[1].res !== 32'd2) begin
      errors++; $display("FAIL rr_responses got n=%0d want id0 r=0 z=1 then id1 r=2", rq.size());
    end
    repeat (3) step();
  endtask

  task automatic test_contention_prio();
    int n0;
    do_reset();
    n0 = 0;
    p0_a = $urandom; p0_b = $urandom; p1_a = $urandom; p1_b = $urandom;
    p0_valid = 1; p1_valid = 1; p_rsp_ready = 1;
    repeat (9) begin
      @(negedge clk);
      checks++;
      if (p1_ready !== 1'b0) begin errors++; $display("FAIL prio_p1_ready got %b want 0", p1_ready); end
      if (p0_ready === 1'b1) n0++;
      if (p_rsp_valid === 1'b1) begin
        checks++;
        if (p_rsp_id !== 1'b0 || p_rsp_result !== p0_a + p0_b) begin
          errors++;
          $display("FAIL prio_rsp got id=%b r=%h want id=0 r=%h", p_rsp_id, p_rsp_result, p0_a + p0_b);
        end
      end
      @(posedge clk);
      #1;
    end
    p0_valid = 0; p1_valid = 0;
    checks++;
    if (n0 != 3) begin errors++; $display("FAIL prio_grants got %0d want 3", n0); end
  endtask

  task automatic test_backpressure();
    do_reset();
    req0_valid = 1; req0_a = 3; req0_b = 4; req0_ctrl = ALU_ADD;
    step();
    req0_valid = 0; rsp_ready = 0;
    req1_valid = 1; req1_a = 1; req1_b = 4; req1_ctrl = ALU_SLL;
    step();
    repeat (5) begin
      checks++;
      if (req1_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_result !== 32'd7) begin
        errors++; $display("FAIL bp_hold got rdy1=%b v=%b r=%0d want 0/1/7", req1_ready, rsp_valid, rsp_result);
      end
      step();
    end
    rsp_ready = 1;
    step();
    checks++;
    if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_after_ready got %b want 1", req1_ready); end
    step();
    req1_valid = 0;
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'd16) begin
      errors++; $display("FAIL bp_req1_rsp got v=%b id=%b r=%0d want 1/1/16", rsp_valid, rsp_id, rsp_result);
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    req0_valid = 1; req0_a = 100; req0_b = 1; req0_ctrl = ALU_SUB;
    step();
    req0_valid = 0;
    rst = 1;
    step();
    rst = 0;
    checks++;
    if (rsp_valid !== 1'b0 || alu_ctrl !== 3'b000 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      errors++;
      $display("FAIL midrst_clear got v=%b ctrl=%b a=%h b=%h want 0/000/0/0", rsp_valid, alu_ctrl, alu_a, alu_b);
    end
    repeat (4) step();
    req0_valid = 1; req1_valid = 1; req0_ctrl = ALU_SLT; req1_ctrl = ALU_SRA;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_first_grant got %b%b want 01", req1_ready, req0_ready);
    end
    step();
    req0_valid = 0; req1_valid = 0;
    repeat (3) step();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_a = $urandom; req1_a = $urandom;
      req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
      req1_b = $urandom_range(0, 40);
      req0_ctrl = 3'($urandom); req1_ctrl = 3'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (4) step();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_contention_rr();
    test_contention_prio();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
